// File: rtl/prog_loader_if.sv
// Stream and instruction-memory bus bundle for prog_loader.
// The master side is the program source and memory; the slave side is the loader.
interface prog_loader_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 15
);
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_last;
  logic              s_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;

  modport master (
    output s_data, s_valid, s_last,
    input  s_ready, mem_addr, mem_wdata, mem_we
  );

  modport slave (
    input  s_data, s_valid, s_last,
    output s_ready, mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/prog_loader.sv
// Program loader: streams words into instruction memory from address 0 while holding the CPU.
// Define PROG_LOADER_CHECKSUM_EN to require a trailing modulo-2**DATA_W checksum word.
module prog_loader #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 15,
  parameter int DEPTH  = 16384
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_req,
  input  logic [ADDR_W-1:0] pc,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_count,
  prog_loader_if.slave      bus
);

`ifdef PROG_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_CHECK, ST_DONE, ST_ERR} state_t;
`else
  typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_DONE, ST_ERR} state_t;
`endif

  localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W+1)'(DEPTH - 1);

  state_t            state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              mem_we_q, mem_we_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              s_ready_q, s_ready_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              accept;
  logic [ADDR_W:0]   acc_addr;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q, sum_d;
`endif

  assign accept   = bus.s_valid & s_ready_q;
  // cnt_q lags by one while a write is pending, so the accepted word lands one further on
  assign acc_addr = cnt_q + (ADDR_W+1)'(mem_we_q);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
`ifdef PROG_LOADER_CHECKSUM_EN
    sum_d       = sum_q;
`endif
    if (mem_we_q) begin
      cnt_d = cnt_q + (ADDR_W+1)'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (load_req) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
          sum_d   = '0;
`endif
        end
      end
      ST_LOAD: begin
        if (accept) begin
          mem_we_d    = 1'b1;
          mem_wdata_d = bus.s_data;
`ifdef PROG_LOADER_CHECKSUM_EN
          sum_d       = sum_q + bus.s_data;
`endif
        end
        if (!load_req) begin
          state_d = ST_ERR;
        end else if (accept && bus.s_last) begin
`ifdef PROG_LOADER_CHECKSUM_EN
          state_d = ST_CHECK;
`else
          state_d = ST_DONE;
`endif
        end else if (accept && acc_addr == LAST_ADDR) begin
          state_d = ST_ERR;
        end
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      ST_CHECK: begin
        if (!load_req) begin
          state_d = ST_ERR;
        end else if (accept) begin
          state_d = (bus.s_data == sum_q) ? ST_DONE : ST_ERR;
        end
      end
`endif
      ST_DONE, ST_ERR: begin
        if (!load_req) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef PROG_LOADER_CHECKSUM_EN
    busy_d = (state_d == ST_LOAD) || (state_d == ST_CHECK);
`else
    busy_d = (state_d == ST_LOAD);
`endif
    s_ready_d  = busy_d;
    cpu_hold_d = (state_d != ST_IDLE);
    done_d     = (state_d == ST_DONE);
    err_d      = (state_d == ST_ERR);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      s_ready_q   <= 1'b0;
      cpu_hold_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      s_ready_q   <= s_ready_d;
      cpu_hold_q  <= cpu_hold_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  assign bus.s_ready   = s_ready_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_addr  = (state_q == ST_IDLE) ? pc : cnt_q[ADDR_W-1:0];
  assign cpu_hold      = cpu_hold_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign word_count    = cnt_q;

endmodule
